// File: rtl/line_follow_pkg.sv
// Shared types and helpers for the line-follower drive controller.
package line_follow_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FOLLOW = 3'd1,
    ST_SEARCH = 3'd2,
    ST_OBST   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [1:0] DIR_FWD = 2'b10;
  localparam logic [1:0] DIR_REV = 2'b01;
  localparam logic [1:0] DIR_BRK = 2'b00;

  function automatic int sat_duty(input int v, input int max_v);
    if (v < 0) return 0;
    else if (v > max_v) return max_v;
    else return v;
  endfunction

endpackage

// File: rtl/line_follow_ctrl_pwm_gen.sv
// Free-running PWM channel: duty latched at counter wrap, force-off clears it at once.
module pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [PWM_W-1:0] i_duty,
  input  logic             i_force_off,
  output logic             o_pwm
);

  logic [PWM_W-1:0] r_cnt;
  logic [PWM_W-1:0] r_duty;
  logic             r_pwm;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_W'(1);
      // Loading only at wrap keeps every period whole; braking bypasses that.
      if (i_force_off) r_duty <= '0;
      else if (r_cnt == '1) r_duty <= i_duty;
      r_pwm <= !i_force_off && (r_cnt < r_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/line_follow_ctrl.sv
// Line-follower drive controller: sensor debounce, proportional steering, search/obstacle FSM.
// Optional soft-start ramp on FOLLOW entry is built when SOFT_START_EN is defined.
module line_follow_ctrl
  import line_follow_pkg::*;
#(
  parameter int N_SENS      = 3,
  parameter int PWM_W       = 8,
  parameter int DUTY_BASE   = 160,
  parameter int GAIN        = 32,
  parameter int DUTY_SEARCH = 128,
  parameter int DEB_CYC     = 1000,
  parameter int SEARCH_CYC  = 50_000_000,
  parameter int CLEAR_CYC   = 10_000_000,
  parameter int RAMP_CYC    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              obstacle,
  input  logic [N_SENS-1:0] sens,
  output logic              pwm_l,
  output logic              pwm_r,
  output logic [1:0]        dir_l,
  output logic [1:0]        dir_r,
  output logic [2:0]        state_o,
  output logic              lost_o
);

  localparam int DEB_W    = $clog2(DEB_CYC + 1);
  localparam int SRCH_W   = $clog2(SEARCH_CYC + 1);
  localparam int CLR_W    = $clog2(CLEAR_CYC + 1);
  localparam int DUTY_MAX = (1 << PWM_W) - 1;

  logic [N_SENS-1:0] r_sync1, r_sync2, r_deb;
  logic [DEB_W-1:0]  r_deb_cnt [N_SENS];
  state_t            r_state;
  logic [1:0]        r_dir_l, r_dir_r;
  logic [SRCH_W-1:0] r_search_t;
  logic [CLR_W-1:0]  r_clear_t;
  logic              r_last_neg, r_lost;
  int                w_pos, w_cnt;
  logic [PWM_W-1:0]  w_req_l, w_req_r;
  logic              w_force;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < N_SENS; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= sens;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_SENS; i++) begin
        if (r_sync2[i] == r_deb[i]) r_deb_cnt[i] <= '0;
        else if (r_deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
      end
    end
  end

  // Sensor i weighs 2i-(N-1): positive means the line sits left of centre.
  always_comb begin
    w_pos = 0;
    w_cnt = 0;
    for (int i = 0; i < N_SENS; i++) begin
      if (r_deb[i]) begin
        w_pos = w_pos + (2 * i - (N_SENS - 1));
        w_cnt = w_cnt + 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dir_l    <= DIR_BRK;
      r_dir_r    <= DIR_BRK;
      r_search_t <= '0;
      r_clear_t  <= '0;
      r_last_neg <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_lost <= (w_cnt == 0);
      if (w_cnt != 0 && w_pos != 0) r_last_neg <= (w_pos < 0);
      if (!enable) begin
        r_state <= ST_IDLE;
        r_dir_l <= DIR_BRK;
        r_dir_r <= DIR_BRK;
      end else begin
        case (r_state)
          ST_IDLE: if (!obstacle) begin
            r_state <= ST_FOLLOW;
            r_dir_l <= DIR_FWD;
            r_dir_r <= DIR_FWD;
          end
          ST_FOLLOW: if (obstacle) begin
            r_state   <= ST_OBST;
            r_dir_l   <= DIR_BRK;
            r_dir_r   <= DIR_BRK;
            r_clear_t <= '0;
          end else if (w_cnt == 0) begin
            r_state    <= ST_SEARCH;
            r_search_t <= '0;
            r_dir_l    <= r_last_neg ? DIR_FWD : DIR_REV;
            r_dir_r    <= r_last_neg ? DIR_REV : DIR_FWD;
          end
          ST_SEARCH: if (obstacle) begin
            r_state   <= ST_OBST;
            r_dir_l   <= DIR_BRK;
            r_dir_r   <= DIR_BRK;
            r_clear_t <= '0;
          end else if (w_cnt != 0) begin
            r_state <= ST_FOLLOW;
            r_dir_l <= DIR_FWD;
            r_dir_r <= DIR_FWD;
          end else if (r_search_t == SRCH_W'(SEARCH_CYC - 1)) begin
            r_state <= ST_HALT;
            r_dir_l <= DIR_BRK;
            r_dir_r <= DIR_BRK;
          end else r_search_t <= r_search_t + SRCH_W'(1);
          ST_OBST: if (obstacle) r_clear_t <= '0;
          else if (r_clear_t == CLR_W'(CLEAR_CYC - 1)) begin
            r_state <= ST_FOLLOW;
            r_dir_l <= DIR_FWD;
            r_dir_r <= DIR_FWD;
          end else r_clear_t <= r_clear_t + CLR_W'(1);
          ST_HALT: ;
          default: begin
            r_state <= ST_IDLE;
            r_dir_l <= DIR_BRK;
            r_dir_r <= DIR_BRK;
          end
        endcase
      end
    end
  end

`ifdef SOFT_START_EN
  localparam int RAMP_W = $clog2(RAMP_CYC + 1);
  logic [PWM_W-1:0]  r_ceil;
  logic [RAMP_W-1:0] r_ramp_t;

  // Ceiling restarts from zero in every braked state and holds through SEARCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ceil   <= '0;
      r_ramp_t <= '0;
    end else if (r_state == ST_FOLLOW) begin
      if (r_ramp_t == RAMP_W'(RAMP_CYC - 1)) begin
        r_ramp_t <= '0;
        if (r_ceil != '1) r_ceil <= r_ceil + PWM_W'(1);
      end else r_ramp_t <= r_ramp_t + RAMP_W'(1);
    end else if (r_state != ST_SEARCH) begin
      r_ceil   <= '0;
      r_ramp_t <= '0;
    end
  end
`else
  logic w_ramp_unused;
  assign w_ramp_unused = (RAMP_CYC != 0);
`endif

  always_comb begin
    w_req_l = '0;
    w_req_r = '0;
    if (r_state == ST_FOLLOW) begin
      w_req_l = PWM_W'(sat_duty(DUTY_BASE - GAIN * w_pos, DUTY_MAX));
      w_req_r = PWM_W'(sat_duty(DUTY_BASE + GAIN * w_pos, DUTY_MAX));
`ifdef SOFT_START_EN
      if (w_req_l > r_ceil) w_req_l = r_ceil;
      if (w_req_r > r_ceil) w_req_r = r_ceil;
`endif
    end else if (r_state == ST_SEARCH) begin
      w_req_l = PWM_W'(DUTY_SEARCH);
      w_req_r = PWM_W'(DUTY_SEARCH);
    end
  end

  assign w_force = (r_state != ST_FOLLOW) && (r_state != ST_SEARCH);

  pwm_gen #(.PWM_W(PWM_W)) u_pwm_l (
    .i_clk(clk), .i_rst(rst), .i_duty(w_req_l), .i_force_off(w_force), .o_pwm(pwm_l)
  );

  pwm_gen #(.PWM_W(PWM_W)) u_pwm_r (
    .i_clk(clk), .i_rst(rst), .i_duty(w_req_r), .i_force_off(w_force), .o_pwm(pwm_r)
  );

  assign dir_l   = r_dir_l;
  assign dir_r   = r_dir_r;
  assign state_o = r_state;
  assign lost_o  = r_lost;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed bench for line_follow_ctrl (default build) plus a GAIN=64 instance for saturation.
module tb_line_follow_ctrl;

  logic       clk, rst, enable, obstacle;
  logic [2:0] sens;
  logic       pwm_l, pwm_r, lost_o;
  logic [1:0] dir_l, dir_r;
  logic [2:0] state_o;
  logic       pwm_l2, pwm_r2, lost_o2;
  logic [1:0] dir_l2, dir_r2;
  logic [2:0] state_o2;

  int n_tests = 0;
  int n_fail  = 0;
  int hl, hr, hl2, hr2, n, found, lost_seen, left_follow;
  int done;

  line_follow_ctrl #(.DEB_CYC(4), .SEARCH_CYC(200), .CLEAR_CYC(50)) dut (
    .clk(clk), .rst(rst), .enable(enable), .obstacle(obstacle), .sens(sens),
    .pwm_l(pwm_l), .pwm_r(pwm_r), .dir_l(dir_l), .dir_r(dir_r),
    .state_o(state_o), .lost_o(lost_o)
  );

  line_follow_ctrl #(.GAIN(64), .DEB_CYC(4), .SEARCH_CYC(200), .CLEAR_CYC(50)) dut_g64 (
    .clk(clk), .rst(rst), .enable(enable), .obstacle(obstacle), .sens(sens),
    .pwm_l(pwm_l2), .pwm_r(pwm_r2), .dir_l(dir_l2), .dir_r(dir_r2),
    .state_o(state_o2), .lost_o(lost_o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // High cycles of each PWM output over one full 256-cycle period.
  task automatic measure(output int ml, output int mr, output int ml2, output int mr2);
    ml = 0; mr = 0; ml2 = 0; mr2 = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_l)  ml++;
      if (pwm_r)  mr++;
      if (pwm_l2) ml2++;
      if (pwm_r2) mr2++;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; obstacle = 1'b0; sens = 3'b000;
    tick(3);
    check("rst_state", state_o, 0);
    check("rst_dir_l", dir_l, 0);
    check("rst_dir_r", dir_r, 0);
    check("rst_pwm_l", pwm_l, 0);
    check("rst_pwm_r", pwm_r, 0);
    check("rst_lost", lost_o, 0);
    check("rst_state_g64", state_o2, 0);
    check("rst_dir_g64", {dir_l2, dir_r2, lost_o2}, 0);
    rst = 1'b0;
    tick(3);
    check("idle_state", state_o, 0);
    check("idle_lost", lost_o, 1);

    // Centred line, then enable.
    sens = 3'b010;
    tick(10);
    enable = 1'b1;
    tick(1);
    check("follow_state", state_o, 1);
    check("follow_dir_l", dir_l, 2);
    check("follow_dir_r", dir_r, 2);
    check("follow_lost", lost_o, 0);
    tick(300);
    measure(hl, hr, hl2, hr2);
    check("centre_duty_l", hl, 160);
    check("centre_duty_r", hr, 160);
    check("centre_duty_l_g64", hl2, 160);
    check("centre_duty_r_g64", hr2, 160);

    // Line on the leftmost sensor: pos = +2.
    sens = 3'b100;
    tick(300);
    measure(hl, hr, hl2, hr2);
    check("left_duty_l", hl, 96);
    check("left_duty_r", hr, 224);
    check("left_duty_l_g64", hl2, 32);
    check("left_duty_r_g64", hr2, 255);

    // Three-cycle dropout must be filtered.
    sens = 3'b010;
    tick(300);
    sens = 3'b000;
    tick(3);
    sens = 3'b010;
    lost_seen = 0; left_follow = 0;
    repeat (20) begin
      @(negedge clk);
      if (lost_o) lost_seen = 1;
      if (state_o != 3'd1) left_follow = 1;
    end
    check("glitch_lost", lost_seen, 0);
    check("glitch_left_follow", left_follow, 0);

    // Rightmost sensor last, then line lost: spin left fwd / right rev.
    sens = 3'b001;
    tick(10);
    sens = 3'b000;
    found = 0;
    for (int k = 0; k < 30 && found == 0; k++) begin
      @(negedge clk);
      if (state_o == 3'd2) found = 1;
    end
    check("search_entry", found, 1);
    check("search_dir_l", dir_l, 2);
    check("search_dir_r", dir_r, 1);
    check("search_lost", lost_o, 1);
    n = 1; done = 0;
    for (int k = 0; k < 400 && done == 0; k++) begin
      @(negedge clk);
      if (state_o == 3'd2) n++;
      else done = 1;
    end
    check("search_cycles", n, 200);
    check("halt_state", state_o, 4);
    check("halt_dir", {dir_l, dir_r}, 0);
    tick(1);
    check("halt_pwm", {pwm_l, pwm_r}, 0);

    // Enable toggle is the only way out of HALT.
    enable = 1'b0;
    tick(1);
    check("disable_idle", state_o, 0);
    sens = 3'b010;
    tick(10);
    enable = 1'b1;
    tick(1);
    check("reenable_follow", state_o, 1);

    // Obstacle hold-off with a pulse restarting the clear timer.
    tick(300);
    obstacle = 1'b1;
    tick(1);
    check("obst_state", state_o, 3);
    check("obst_dir", {dir_l, dir_r}, 0);
    tick(1);
    check("obst_pwm", {pwm_l, pwm_r}, 0);
    obstacle = 1'b0;
    tick(30);
    check("obst_hold", state_o, 3);
    obstacle = 1'b1;
    tick(1);
    obstacle = 1'b0;
    n = 0; done = 0;
    for (int k = 0; k < 100 && done == 0; k++) begin
      @(negedge clk);
      n++;
      if (state_o == 3'd1) done = 1;
    end
    check("clear_cycles", n, 50);

    // Asynchronous reset while the PWM is high.
    tick(300);
    found = 0;
    for (int k = 0; k < 300 && found == 0; k++) begin
      @(negedge clk);
      if (pwm_l) found = 1;
    end
    check("pre_reset_pwm_high", found, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm_l", pwm_l, 0);
    check("async_rst_pwm_r", pwm_r, 0);
    check("async_rst_dir", {dir_l, dir_r}, 0);
    check("async_rst_state", state_o, 0);
    tick(2);
    rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
